// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes, mult/div
// sequencing with HI/LO interlock, and a saturating stall-cycle counter.
module hazard_ctrl #(
  parameter int REG_W     = 5,
  parameter int MD_CYCLES = 32,
  parameter int CNT_W     = 6,
  parameter int PERF_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_md_start,
  input  logic              id_reads_hilo,
  input  logic              ex_memread,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic              ex_branch_taken,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              md_start,
  output logic              md_busy,
  output logic              md_done,
  output logic [PERF_W-1:0] stall_cycles
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  // Count reaches zero in the md_done cycle, MD_CYCLES-1 cycles after launch.
  localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MD_CYCLES - 2);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   w_count_nxt;
  logic [PERF_W-1:0]  r_stall_cycles;

  logic w_rs_hit;
  logic w_rt_hit;
  logic w_lu;
  logic w_busy;
  logic w_last;
  logic w_mdh;
  logic w_can_launch;

  logic w_pc_en;
  logic w_ifid_en;
  logic w_ifid_flush;
  logic w_idex_flush;
  logic w_md_start;
  logic w_md_busy;
  logic w_md_done;

  assign w_rs_hit     = id_uses_rs & (id_rs == ex_rd);
  assign w_rt_hit     = id_uses_rt & (id_rt == ex_rd);
  assign w_lu         = ex_memread & (ex_rd != '0) & (w_rs_hit | w_rt_hit);
  assign w_busy       = (r_state == S_BUSY);
  assign w_last       = w_busy & (r_count == '0);
  assign w_mdh        = w_busy & ~w_last & (id_md_start | id_reads_hilo);
  assign w_can_launch = (r_state == S_IDLE) | w_last;

  always_comb begin
    w_pc_en      = 1'b0;
    w_ifid_en    = 1'b0;
    w_ifid_flush = 1'b0;
    w_idex_flush = 1'b0;
    w_md_start   = 1'b0;
    w_md_busy    = 1'b0;
    w_md_done    = 1'b0;
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;

    // The unit keeps counting through stalls and flushes.
    if (w_busy) begin
      w_count_nxt = r_count - 1'b1;
      if (w_last) begin
        w_state_nxt = S_IDLE;
      end
    end

    if (!reset) begin
      w_md_busy = w_busy;
      w_md_done = w_last;
      if (ex_branch_taken) begin
        w_pc_en      = 1'b1;
        w_ifid_en    = 1'b1;
        w_ifid_flush = 1'b1;
        w_idex_flush = 1'b1;
      end else if (w_lu | w_mdh) begin
        w_idex_flush = 1'b1;
      end else begin
        w_pc_en    = 1'b1;
        w_ifid_en  = 1'b1;
        w_md_start = id_md_start & w_can_launch;
        if (w_md_start) begin
          w_state_nxt = S_BUSY;
          w_count_nxt = MD_LOAD;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cycles <= '0;
    end else if (!w_pc_en && (r_stall_cycles != '1)) begin
      r_stall_cycles <= r_stall_cycles + 1'b1;
    end
  end

  assign pc_en        = w_pc_en;
  assign ifid_en      = w_ifid_en;
  assign ifid_flush   = w_ifid_flush;
  assign idex_flush   = w_idex_flush;
  assign md_start     = w_md_start;
  assign md_busy      = w_md_busy;
  assign md_done      = w_md_done;
  assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with MD_CYCLES=4 and PERF_W=4.
module tb_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rs;
  logic       id_uses_rt;
  logic       id_md_start;
  logic       id_reads_hilo;
  logic       ex_memread;
  logic [4:0] ex_rd;
  logic       ex_branch_taken;
  logic       pc_en;
  logic       ifid_en;
  logic       ifid_flush;
  logic       idex_flush;
  logic       md_start;
  logic       md_busy;
  logic       md_done;
  logic [3:0] stall_cycles;

  int total;
  int bad;

  hazard_ctrl #(
    .REG_W(5),
    .MD_CYCLES(4),
    .CNT_W(3),
    .PERF_W(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .id_rs(id_rs),
    .id_rt(id_rt),
    .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt),
    .id_md_start(id_md_start),
    .id_reads_hilo(id_reads_hilo),
    .ex_memread(ex_memread),
    .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken),
    .pc_en(pc_en),
    .ifid_en(ifid_en),
    .ifid_flush(ifid_flush),
    .idex_flush(idex_flush),
    .md_start(md_start),
    .md_busy(md_busy),
    .md_done(md_done),
    .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // eo = {pc_en, ifid_en, ifid_flush, idex_flush, md_start, md_busy, md_done}
  typedef struct {
    string      name;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       mds;
    logic       hilo;
    logic       mr;
    logic [4:0] rd;
    logic       br;
    logic [6:0] eo;
    logic [3:0] es;
  } vec_t;

  vec_t tv[$];

  function automatic logic [6:0] outs();
    return {pc_en, ifid_en, ifid_flush, idex_flush, md_start, md_busy, md_done};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                       input logic urt, input logic mds, input logic hilo,
                       input logic mr, input logic [4:0] rd, input logic br);
    id_rs           = rs;
    id_rt           = rt;
    id_uses_rs      = urs;
    id_uses_rt      = urt;
    id_md_start     = mds;
    id_reads_hilo   = hilo;
    ex_memread      = mr;
    ex_rd           = rd;
    ex_branch_taken = br;
  endtask

  task automatic add(input string n, input logic [4:0] rs, input logic [4:0] rt,
                     input logic urs, input logic urt, input logic mds, input logic hilo,
                     input logic mr, input logic [4:0] rd, input logic br,
                     input logic [6:0] eo, input logic [3:0] es);
    vec_t v;
    v.name = n; v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.mds = mds;
    v.hilo = hilo; v.mr = mr; v.rd = rd; v.br = br; v.eo = eo; v.es = es;
    tv.push_back(v);
  endtask

  task automatic nop();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  initial begin
    int done_seen;
    total = 0;
    bad   = 0;

    //   name             rs     rt     urs   urt   mds   hilo  mr    rd     br    outputs      stall
    add("idle_nop",       5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 7'b1100000, 4'd0);
    add("loaduse_rt",     5'd0,  5'd8,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd8,  1'b0, 7'b0001000, 4'd0);
    add("lu_release",     5'd0,  5'd8,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd8,  1'b0, 7'b1100000, 4'd1);
    add("loaduse_rs",     5'd5,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5,  1'b0, 7'b0001000, 4'd1);
    add("lu_rs_unused",   5'd5,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5,  1'b0, 7'b1100000, 4'd2);
    add("lu_no_match",    5'd6,  5'd7,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5,  1'b0, 7'b1100000, 4'd2);
    add("zero_reg",       5'd0,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0,  1'b0, 7'b1100000, 4'd2);
    add("branch_beats",   5'd0,  5'd8,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd8,  1'b1, 7'b1111000, 4'd2);
    add("after_branch",   5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 7'b1100000, 4'd2);
    add("md_launch",      5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 7'b1100100, 4'd2);
    add("hilo_stall1",    5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0,  1'b0, 7'b0001010, 4'd2);
    add("hilo_stall2",    5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0,  1'b0, 7'b0001010, 4'd3);
    add("hilo_at_done",   5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0,  1'b0, 7'b1100011, 4'd4);
    add("md_idle_again",  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 7'b1100000, 4'd4);
    add("b2b_launch1",    5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 7'b1100100, 4'd4);
    add("b2b_busy",       5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 7'b1100010, 4'd4);
    add("md_while_busy",  5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 7'b0001010, 4'd4);
    add("b2b_done_start", 5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 7'b1100111, 4'd5);
    add("b2b_busy2",      5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 7'b1100010, 4'd5);
    add("branch_in_busy", 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0,  1'b1, 7'b1111010, 4'd5);
    add("b2b_done2",      5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 7'b1100011, 4'd5);
    add("b2b_idle",       5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 7'b1100000, 4'd5);

    // Reset: outputs forced low even with a load-use and mult/div request present.
    reset = 1'b1;
    drive(5'd0, 5'd8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd8, 1'b1);
    #2;
    chk("reset_outs", 32'(outs()), 32'd0);
    chk("reset_stall", 32'(stall_cycles), 32'd0);
    nop();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    foreach (tv[i]) begin
      drive(tv[i].rs, tv[i].rt, tv[i].urs, tv[i].urt, tv[i].mds, tv[i].hilo,
            tv[i].mr, tv[i].rd, tv[i].br);
      #2;
      chk({tv[i].name, "_outs"}, 32'(outs()), 32'(tv[i].eo));
      chk({tv[i].name, "_stall"}, 32'(stall_cycles), 32'(tv[i].es));
      @(posedge clk);
      #1;
    end

    // Reset two cycles after a launch aborts the unit.
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    #2;
    chk("rst_mid_launch", 32'(md_start), 32'd1);
    @(posedge clk); #1;
    nop();
    @(posedge clk); #1;
    drive(5'd0, 5'd8, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0);
    #1;
    chk("rst_mid_pre_busy", 32'(md_busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_mid_outs", 32'(outs()), 32'd0);
    chk("rst_mid_stall", 32'(stall_cycles), 32'd0);
    nop();
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_rel_outs", 32'(outs()), 32'b1100000);
    done_seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (md_done !== 1'b0 || md_busy !== 1'b0) done_seen++;
    end
    chk("rst_rel_no_done", 32'(done_seen), 32'd0);
    chk("rst_rel_stall", 32'(stall_cycles), 32'd0);

    // Saturation: 2^PERF_W+5 stalled cycles.
    drive(5'd0, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0);
    #1;
    for (int c = 0; c < 21; c++) begin
      @(posedge clk); #1;
      if (c == 9) chk("sat_mid", 32'(stall_cycles), 32'd10);
    end
    chk("sat_still_stalled", 32'(pc_en), 32'd0);
    chk("sat_hold", 32'(stall_cycles), 32'd15);
    nop();
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("sat_after", 32'(stall_cycles), 32'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
